// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back arbiter (ALU vs load return) for the register file
// plus a pending-load scoreboard with a sticky double-issue error flag.
module regfile_wb_arbiter #(
    parameter int DATA_W = 18,
    parameter int SEL_W  = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_alu_valid,
    input  logic [SEL_W-1:0]    i_alu_sel,
    input  logic [DATA_W-1:0]   i_alu_data,
    output logic                o_alu_ready,
    input  logic                i_mem_valid,
    input  logic [SEL_W-1:0]    i_mem_sel,
    input  logic [DATA_W-1:0]   i_mem_data,
    output logic                o_mem_ready,
    input  logic                i_ld_issue,
    input  logic [SEL_W-1:0]    i_ld_sel,
    output logic                o_wr_en,
    output logic [SEL_W-1:0]    o_wr_sel,
    output logic [DATA_W-1:0]   o_wr_data,
    output logic [2**SEL_W-1:0] o_pend_mask,
    output logic                o_ld_err
);
    localparam int N = 2**SEL_W;

    logic         r_last_mem;
    logic         w_alu_xfer;
    logic         w_mem_xfer;
    logic         w_err;
    logic [N-1:0] w_set;
    logic [N-1:0] w_clr;

    // Readies are gated by reset so every output reads 0 while rst_n is low.
    always_comb begin
        o_alu_ready = i_rst_n & i_alu_valid & (~i_mem_valid | r_last_mem);
        o_mem_ready = i_rst_n & i_mem_valid & (~i_alu_valid | ~r_last_mem);
        w_alu_xfer  = i_alu_valid & o_alu_ready;
        w_mem_xfer  = i_mem_valid & o_mem_ready;
        w_set       = i_ld_issue ? N'(1) << i_ld_sel : '0;
        w_clr       = w_mem_xfer ? N'(1) << i_mem_sel : '0;
        w_err       = i_ld_issue & o_pend_mask[i_ld_sel] & ~w_clr[i_ld_sel];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_mem  <= 1'b1;
            o_wr_en     <= 1'b0;
            o_wr_sel    <= '0;
            o_wr_data   <= '0;
            o_pend_mask <= '0;
            o_ld_err    <= 1'b0;
        end else begin
            o_wr_en <= w_alu_xfer | w_mem_xfer;
            if (w_alu_xfer | w_mem_xfer) begin
                r_last_mem <= w_mem_xfer;
                o_wr_sel   <= w_alu_xfer ? i_alu_sel : i_mem_sel;
                o_wr_data  <= w_alu_xfer ? i_alu_data : i_mem_data;
            end
            // A new load supersedes a returning one to the same register.
            o_pend_mask <= (o_pend_mask & ~w_clr) | w_set;
            if (w_err)
                o_ld_err <= 1'b1;
        end
    end
endmodule
